// File: rtl/riscv_pkg.sv
// riscv_pkg: funct3 codes, LSU FSM state encoding and byte-enable constants.
package riscv_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} lsu_state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane replication, load extraction and error decode.
// Error decode is active only with LSU_MISALIGN_TRAP_EN; otherwise accesses are forced aligned.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_we,
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [2:0]       i_ld_funct3,
  input  logic [1:0]       i_ld_addr,
  input  logic [WIDTH-1:0] i_rdata,
  output logic             o_err,
  output logic [3:0]       o_be,
  output logic [WIDTH-1:0] o_wdata,
  output logic [WIDTH-1:0] o_rdata
);
  logic             w_ill, w_ld_ill;
  logic [1:0]       w_sz, w_off, w_ld_sz, w_ld_off;
  logic [WIDTH-1:0] w_sh;
  // Illegal funct3 collapses to a word access; word and halfword lanes ignore misaligned low bits.
  always_comb begin
    w_ill    = i_we ? !(i_funct3 inside {F3_SB, F3_SH, F3_SW})
                    : !(i_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    w_sz     = w_ill ? 2'b10 : i_funct3[1:0];
    w_off    = w_sz == 2'b00 ? i_addr : w_sz == 2'b01 ? {i_addr[1], 1'b0} : 2'b00;
    o_be     = !i_we ? BE_W : w_sz == 2'b00 ? BE_B << w_off : w_sz == 2'b01 ? BE_H << w_off : BE_W;
    o_wdata  = w_sz == 2'b00 ? {(WIDTH/8){i_wdata[7:0]}}
             : w_sz == 2'b01 ? {(WIDTH/16){i_wdata[15:0]}} : i_wdata;
    w_ld_ill = !(i_ld_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    w_ld_sz  = w_ld_ill ? 2'b10 : i_ld_funct3[1:0];
    w_ld_off = w_ld_sz == 2'b00 ? i_ld_addr : w_ld_sz == 2'b01 ? {i_ld_addr[1], 1'b0} : 2'b00;
    w_sh     = i_rdata >> {w_ld_off, 3'b000};
    o_rdata  = w_ld_sz == 2'b00 ? {{(WIDTH-8){~i_ld_funct3[2] & w_sh[7]}}, w_sh[7:0]}
             : w_ld_sz == 2'b01 ? {{(WIDTH-16){~i_ld_funct3[2] & w_sh[15]}}, w_sh[15:0]} : w_sh;
  end
`ifdef LSU_MISALIGN_TRAP_EN
  assign o_err = w_ill | (w_sz == 2'b01 & i_addr[0]) | (w_sz == 2'b10 & |i_addr);
`else
  assign o_err = 1'b0;
`endif
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit FSM (IDLE/ISSUE/RESP) with req/ack memory handshake.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned/illegal accesses into error responses.
module lsu
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             busy
);
  lsu_state_e       r_state;
  logic             r_mem_req, r_mem_we, r_rsp_valid, r_rsp_err;
  logic [WIDTH-1:0] r_mem_addr, r_mem_wdata, r_rsp_rdata;
  logic [3:0]       r_mem_be;
  logic [2:0]       r_funct3;
  logic [1:0]       r_lo;
  logic             w_err;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata, w_ld;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .i_we       (req_we),
    .i_funct3   (req_funct3),
    .i_addr     (req_addr[1:0]),
    .i_wdata    (req_wdata),
    .i_ld_funct3(r_funct3),
    .i_ld_addr  (r_lo),
    .i_rdata    (mem_rdata),
    .o_err      (w_err),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_rdata    (w_ld)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_funct3    <= '0;
      r_lo        <= '0;
    end else
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_funct3 <= req_funct3;
          r_lo     <= req_addr[1:0];
          if (w_err) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_state     <= S_ISSUE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= req_we;
            r_mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
          end
        end
        S_ISSUE: if (mem_ack) begin
          r_state     <= S_RESP;
          r_mem_req   <= 1'b0;
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= r_mem_we ? '0 : w_ld;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: r_state <= S_IDLE;
      endcase

  assign req_ready = r_state == S_IDLE;
  assign busy      = r_state != S_IDLE;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized and directed checks of lsu against a byte-level reference model.
// Model follows LSU_MISALIGN_TRAP_EN the same way as the design build.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic        req_ready, mem_req, mem_we, rsp_valid, rsp_err, busy;
  logic [31:0] mem_addr, mem_wdata, rsp_rdata;
  logic [3:0]  mem_be;
  int          n_chk = 0, n_fail = 0;

  lsu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                output logic err, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] rd);
    bit          illegal;
    int          n, a, lane;
    logic [31:0] mask, v;
    illegal = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = illegal ? 4 : (f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4);
    a = int'(addr[1:0]);
    lane = a - a % n;
`ifdef LSU_MISALIGN_TRAP_EN
    err = illegal || (a % n != 0);
`else
    err = 1'b0;
`endif
    be = we ? 4'(((1 << n) - 1) << lane) : 4'hf;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % n) +: 8];
    mask = n == 4 ? 32'hffff_ffff : (32'd1 << (8 * n)) - 32'd1;
    v = (rdata >> (8 * lane)) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    rd = (we || err) ? 32'd0 : v;
  endfunction

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input int dly, input bit hold);
    logic        err;
    logic [3:0]  be;
    logic [31:0] wd, rd;
    model(we, f3, addr, wdata, rdata, err, be, wd, rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    chk("ready", req_ready, 1);
    @(posedge clk); #1;
    if (!hold) begin
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      req_funct3 = 3'($urandom); req_we = 1'($urandom);
    end
    chk("busy", busy, 1);
    if (err) begin
      chk("err_memreq", mem_req, 0);
      chk("err_valid", rsp_valid, 1);
      chk("err_flag", rsp_err, 1);
      chk("err_rdata", rsp_rdata, 0);
    end else begin
      chk("memreq", mem_req, 1);
      chk("mem_we", mem_we, we);
      chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
      chk("mem_be", mem_be, be);
      if (we) chk("mem_wdata", mem_wdata, wd);
      for (int i = 0; i < dly; i++) begin
        @(posedge clk); #1;
        chk("wait_req", mem_req, 1);
        chk("wait_addr", mem_addr, {addr[31:2], 2'b00});
        chk("wait_valid", rsp_valid, 0);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err", rsp_err, 0);
      chk("rsp_rdata", rsp_rdata, rd);
      chk("rsp_memreq", mem_req, 0);
      chk("rsp_busy", busy, 1);
    end
    mem_ack = 1'($urandom);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("done_valid", rsp_valid, 0);
    chk("done_ready", req_ready, 1);
    chk("done_memreq", mem_req, 0);
  endtask

  initial begin
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    @(negedge clk); rst_n = 1'b1;
    txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1'b0);
    txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF7F01, 0, 1'b0);
    txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF7F01, 1, 1'b0);
    txn(1'b1, 3'b000, 32'h102, 32'h123456AB, 32'h0, 1, 1'b0);
    txn(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 0, 1'b0);
    txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001C0DE, 0, 1'b0);
    txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h11223344, 1, 1'b0);
    txn(1'b0, 3'b001, 32'h103, 32'h0, 32'hF00D8765, 0, 1'b0);
    txn(1'b1, 3'b111, 32'h106, 32'hCAFEF00D, 32'h0, 0, 1'b0);
    txn(1'b0, 3'b110, 32'h203, 32'h0, 32'hA5A55A5A, 0, 1'b0);
    txn(1'b0, 3'b010, 32'h200, 32'h0, 32'h0BADF00D, 1, 1'b1);
    txn(1'b1, 3'b010, 32'h204, 32'h01020304, 32'h0, 0, 1'b1);
    txn(1'b0, 3'b001, 32'h206, 32'h0, 32'h7FFF8000, 2, 1'b0);
    for (int k = 0; k < 60; k++)
      txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("pre_rst_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_memreq", mem_req, 0);
    chk("async_ready", req_ready, 1);
    chk("async_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_req", mem_req, 0);
    end
    mem_ack = 1'b0;
    txn(1'b0, 3'b000, 32'h301, 32'h0, 32'h00008000, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
